fp_exec_unit: RTL and testbench

FP_EXEC_UNIT -- requirements
Module: fp_exec_unit

---
 rtl/fp_exec_unit_if.sv | 54 +++++
 rtl/fp_exec_unit.sv | 137 +++++++++++++
 tb/tb_fp_exec_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_exec_unit_if.sv
// Bus between the FP execution unit and its environment: the issue port,
// the registered drive to the external combinational FP_ALU, the ALU
// outputs coming back, and the writeback/status outputs.
//
// Handshake: start is a request, and it is taken on a rising edge only
// while busy is low (IDLE). There is no separate ready signal: !busy is
// the ready. A request made while busy is dropped, not queued. done is a
// one-cycle strobe in the cycle after capture. result, wb_dest, cc, cause
// and flags stay valid after done until the next capture or accept.
interface fp_exec_unit_if;
  logic        start;
  logic [2:0]  func;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [4:0]  dest;
  logic        flag_clr;

  logic [31:0] alu_num1;
  logic [31:0] alu_num2;
  logic [2:0]  alu_func;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_underflow;
  logic        alu_inexact;
  logic        alu_div_by_zero;
  logic        alu_QNaN;
  logic        alu_SNaN;

  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wb_dest;
  logic        wb_en;
  logic [2:0]  cc;
  logic [5:0]  cause;
  logic [5:0]  flags;
  logic [1:0]  dbg_state;

  modport slave (
    input  start, func, num1, num2, dest, flag_clr,
    input  alu_result, alu_overflow, alu_underflow, alu_inexact,
    input  alu_div_by_zero, alu_QNaN, alu_SNaN,
    output alu_num1, alu_num2, alu_func,
    output busy, done, result, wb_dest, wb_en, cc, cause, flags, dbg_state
  );

  modport master (
    output start, func, num1, num2, dest, flag_clr,
    output alu_result, alu_overflow, alu_underflow, alu_inexact,
    output alu_div_by_zero, alu_QNaN, alu_SNaN,
    input  alu_num1, alu_num2, alu_func,
    input  busy, done, result, wb_dest, wb_en, cc, cause, flags, dbg_state
  );
endinterface

// File: rtl/fp_exec_unit.sv
// FP execution unit sequencer. It latches one operation and drives it to
// an external combinational FP_ALU. It waits an opcode-dependent settle
// time and then captures the result and exception flags. It produces a
// writeback strobe and keeps the compare code and sticky flags.
module fp_exec_unit #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  fp_exec_unit_if.slave bus
);

  localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_alu_num1;
  logic [31:0] r_alu_num2;
  logic [2:0]  r_alu_func;
  logic [31:0] r_result;
  logic [4:0]  r_wb_dest;
  logic        r_wb_en;
  logic        r_done;
  logic        r_busy;
  logic [2:0]  r_cc;
  logic [5:0]  r_cause;
  logic [5:0]  r_flags;

  logic [CW-1:0] w_lat;
  logic [5:0]    w_cause_new;
  logic          w_capture;

  // Settle time for the requested opcode: mul and div/sqrt are multi-cycle
  always_comb begin
    w_lat = CW'(1);
    case (bus.func)
      3'b010:         w_lat = CW'(MUL_CYCLES);
      3'b011, 3'b101: w_lat = CW'(DIV_CYCLES);
      default:        w_lat = CW'(1);
    endcase
  end

  // Flags of the op in flight. The reserved opcode never reports any.
  always_comb begin
    w_cause_new = {bus.alu_SNaN, bus.alu_QNaN, bus.alu_div_by_zero,
                   bus.alu_overflow, bus.alu_underflow, bus.alu_inexact};
    if (r_alu_func == 3'b111) w_cause_new = 6'b0;
  end

  assign w_capture = (r_state == S_EXEC) && (r_cnt == CW'(1));

  // Main sequencer: accept, count down the settle time, capture, strobe done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_alu_num1 <= '0;
      r_alu_num2 <= '0;
      r_alu_func <= '0;
      r_result   <= '0;
      r_wb_dest  <= '0;
      r_wb_en    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_cc       <= '0;
      r_cause    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_alu_num1 <= bus.num1;
            r_alu_num2 <= bus.num2;
            r_alu_func <= bus.func;
            r_wb_dest  <= bus.dest;
            r_cnt      <= w_lat;
            r_busy     <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_capture) begin
            r_result <= bus.alu_result;
            r_cause  <= w_cause_new;
            if (r_alu_func == 3'b100) r_cc <= bus.alu_result[2:0];
            // Compares and the reserved opcode write no register.
            // A signalling NaN also suppresses the write.
            r_wb_en  <= (r_alu_func != 3'b100) && (r_alu_func != 3'b111) &&
                        !bus.alu_SNaN;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags. A clear on the capture edge keeps only the new op's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_capture) begin
      r_flags <= (bus.flag_clr ? 6'b0 : r_flags) | w_cause_new;
    end else if (bus.flag_clr) begin
      r_flags <= '0;
    end
  end

  assign bus.alu_num1  = r_alu_num1;
  assign bus.alu_num2  = r_alu_num2;
  assign bus.alu_func  = r_alu_func;
  assign bus.result    = r_result;
  assign bus.wb_dest   = r_wb_dest;
  assign bus.wb_en     = r_wb_en;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.cc        = r_cc;
  assign bus.cause     = r_cause;
  assign bus.flags     = r_flags;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_fp_exec_unit.sv
// Bench for fp_exec_unit. The bench plays the FP_ALU by driving
// alu_result and the flags. The driver pushes the expected completion of
// each op into a queue. A monitor pops and compares whenever done is seen.
module tb_fp_exec_unit;

  localparam int MUL = 2;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_exec_unit_if bus();

  fp_exec_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        wb_en;
    logic [5:0]  cause;
    logic [5:0]  flags;
    logic [2:0]  cc;
    logic [31:0] n1;
    logic [2:0]  func;
    logic [7:0]  lat;
    logic [31:0] acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic [5:0] m_flags = 6'b0;
  logic [2:0] m_cc = 3'b0;

  // clock/reset block: free-running cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int lat_of(input logic [2:0] f);
    case (f)
      3'b010:         return MUL;
      3'b011, 3'b101: return DIV;
      default:        return 1;
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", bus.done, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result",   bus.result,   mon_e.result);
        check("wb_dest",  bus.wb_dest,  mon_e.dest);
        check("wb_en",    bus.wb_en,    mon_e.wb_en);
        check("cause",    bus.cause,    mon_e.cause);
        check("flags",    bus.flags,    mon_e.flags);
        check("cc",       bus.cc,       mon_e.cc);
        check("alu_num1", bus.alu_num1, mon_e.n1);
        check("alu_func", bus.alu_func, mon_e.func);
        check("latency",  64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_num1"}, bus.alu_num1, 0);
    check({tag, "_alu_num2"}, bus.alu_num2, 0);
    check({tag, "_alu_func"}, bus.alu_func, 0);
    check({tag, "_result"},   bus.result,   0);
    check({tag, "_wb_dest"},  bus.wb_dest,  0);
    check({tag, "_wb_en"},    bus.wb_en,    0);
    check({tag, "_done"},     bus.done,     0);
    check({tag, "_busy"},     bus.busy,     0);
    check({tag, "_cc"},       bus.cc,       0);
    check({tag, "_cause"},    bus.cause,    0);
    check({tag, "_flags"},    bus.flags,    0);
  endtask

  // driver: issue one op from IDLE, optionally poke start mid-op and/or
  // pulse flag_clr on the capture edge, then wait for return to IDLE
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] res, input logic [5:0] fl,
                       input bit clr, input bit poke);
    exp_t e;
    int   lat;
    int   n;
    lat = lat_of(f);
    bus.func = f;
    bus.num1 = a;
    bus.num2 = b;
    bus.dest = d;
    bus.alu_result = res;
    {bus.alu_SNaN, bus.alu_QNaN, bus.alu_div_by_zero,
     bus.alu_overflow, bus.alu_underflow, bus.alu_inexact} = fl;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.acc_cyc = cyc;
    e.result  = res;
    e.dest    = d;
    e.n1      = a;
    e.func    = f;
    e.lat     = 8'(lat);
    e.cause   = (f == 3'b111) ? 6'b0 : fl;
    m_flags   = (clr ? 6'b0 : m_flags) | e.cause;
    e.flags   = m_flags;
    if (f == 3'b100) m_cc = res[2:0];
    e.cc      = m_cc;
    e.wb_en   = (f != 3'b100) && (f != 3'b111) && !fl[5];
    exp_q.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      bus.start    = poke && (k == 1);
      bus.num1     = (poke && k == 1) ? ~a : a;
      bus.flag_clr = clr && (k == lat);
      @(posedge clk); #1;
    end
    bus.start    = 1'b0;
    bus.flag_clr = 1'b0;
    bus.num1     = a;
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("busy_timeout", bus.busy, 1'b0);
  endtask

  task automatic clear_flags();
    bus.flag_clr = 1'b1;
    @(posedge clk); #1;
    bus.flag_clr = 1'b0;
    m_flags = 6'b0;
    check("flag_clr_alone", bus.flags, 6'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.func = 3'b0; bus.num1 = '0; bus.num2 = '0; bus.dest = '0;
    bus.flag_clr = 1'b0; bus.alu_result = '0;
    {bus.alu_SNaN, bus.alu_QNaN, bus.alu_div_by_zero,
     bus.alu_overflow, bus.alu_underflow, bus.alu_inexact} = 6'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // clean add, single-cycle settle
    issue(3'b000, 32'h41040000, 32'h3FA00000, 5'd5, 32'h41180000, 6'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_result",  bus.result,  32'h41180000);
    check("hold_wb_dest", bus.wb_dest, 5'd5);

    // divide by zero, then a clean add keeps the sticky flag
    issue(3'b011, 32'h41040000, 32'h0, 5'd7, 32'h7F800000, 6'b001000, 1'b0, 1'b0);
    issue(3'b000, 32'h3F800000, 32'h3F800000, 5'd8, 32'h40000000, 6'b0, 1'b0, 1'b0);
    check("sticky_after_add", bus.flags, 6'b001000);

    // compare writes cc only
    issue(3'b100, 32'hC1040000, 32'h3FC00000, 5'd9, 32'h00000004, 6'b0, 1'b0, 1'b0);
    check("cmp_cc", bus.cc, 3'b100);

    // mul with start poked during EXEC
    issue(3'b010, 32'h40400000, 32'h40000000, 5'd10, 32'h40C00000, 6'b0, 1'b0, 1'b1);

    // reserved opcode and a signalling NaN
    issue(3'b111, 32'h1, 32'h2, 5'd11, 32'h12345678, 6'b111111, 1'b0, 1'b0);
    issue(3'b001, 32'h7F800001, 32'h0, 5'd12, 32'h7FC00000, 6'b100000, 1'b0, 1'b0);

    // flag_clr on the capture edge with prior overflow
    clear_flags();
    issue(3'b000, 32'h7F000000, 32'h7F000000, 5'd13, 32'h7F800000, 6'b000100, 1'b0, 1'b0);
    issue(3'b000, 32'h3F800000, 32'h33800000, 5'd14, 32'h3F800000, 6'b000001, 1'b1, 1'b0);
    check("clr_on_capture", bus.flags, 6'b000001);

    // reset on the second EXEC edge of a divide
    bus.func = 3'b011; bus.num1 = 32'h41040000; bus.num2 = 32'h40000000; bus.dest = 5'd15;
    bus.alu_result = 32'h40840000;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_flags = 6'b0;
    m_cc = 3'b0;
    check_all_zero("abort");
    repeat (6) @(posedge clk);
    #1;

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [5:0] fl;
      fl = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) fl[5] = 1'b0;
      if ($urandom_range(0, 9) == 0) clear_flags();
      issue(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            $urandom, fl, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
